// File: rtl/mem_defs.sv
// Memory geometry and load/store FSM encoding, shared by the load/store unit
// and the data memory.
package mem_defs;

  localparam int ADDR_W     = 12;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = 6;
  localparam int WORD_W     = BYTE_W * WORD_BYTES;

  localparam logic [2:0] LAST_CNT = 3'(WORD_BYTES - 1);

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_XFER = 2'd1,
    LSU_DONE = 2'd2
  } lsu_state_t;

  // Byte 0 of a word is its most significant byte, so lane cnt starts here.
  function automatic int lane_lsb(logic [2:0] cnt);
    return WORD_W - BYTE_W * (int'(cnt) + 1);
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Splits one 48-bit load/store into six sequential byte accesses on a
// byte-wide memory port and returns the result through a valid/ready response.
module load_store_unit
  import mem_defs::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [BYTE_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [BYTE_W-1:0] mem_rdata
);

  lsu_state_t        state;
  lsu_state_t        state_nxt;
  logic [2:0]        cnt;
  logic              write_q;
  logic [ADDR_W-1:0] adr_q;
  logic [WORD_W-1:0] wdata_q;
  logic [WORD_W-1:0] rdata_q;
  logic              accept;
  logic              xfer;

  assign accept = req_valid && (state == LSU_IDLE);
  assign xfer   = (state == LSU_XFER);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LSU_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: if (accept) state_nxt = LSU_XFER;
      LSU_XFER: if (cnt == LAST_CNT) state_nxt = LSU_DONE;
      LSU_DONE: if (resp_ready) state_nxt = LSU_IDLE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  // Request capture and byte-lane demux for load data
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      write_q <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        LSU_IDLE: begin
          if (accept) begin
            write_q <= req_write;
            adr_q   <= req_adr;
            wdata_q <= req_wdata;
            rdata_q <= '0;
            cnt     <= '0;
          end
        end
        LSU_XFER: begin
          if (!write_q) begin
            rdata_q[lane_lsb(cnt) +: BYTE_W] <= mem_rdata;
          end
          cnt <= (cnt == LAST_CNT) ? 3'd0 : cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Memory port is decoded from state; address wraps modulo 2^ADDR_W
  always_comb begin
    req_ready  = (state == LSU_IDLE);
    resp_valid = (state == LSU_DONE);
    resp_rdata = rdata_q;
    mem_write  = xfer && write_q;
    mem_read   = xfer && !write_q;
    mem_adr    = xfer ? adr_q + ADDR_W'(cnt) : '0;
    mem_wdata  = mem_write ? wdata_q[lane_lsb(cnt) +: BYTE_W] : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array memory, transaction-level reference
// model with per-cycle comparison, directed scenarios and random traffic.
module tb_load_store_unit;
  import mem_defs::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [11:0] req_adr = '0;
  logic [47:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [47:0] resp_rdata;
  logic [11:0] mem_adr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_adr(req_adr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // Data memory seen by the DUT
  logic [7:0] mem [0:4095];
  logic       clr_mem = 1'b1;
  assign mem_rdata = mem[mem_adr];
  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
    end else if (mem_write) begin
      mem[mem_adr] <= mem_wdata;
    end
  end

  int tests = 0;
  int fails = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: m_k = 0 idle, 1..6 = byte access m_k-1, 7 = response pending
  logic [7:0]  ref_mem [0:4095];
  int          m_k = 0;
  logic        m_write;
  logic [11:0] m_adr;
  logic [47:0] m_wdata;
  logic [47:0] m_rdata;

  function automatic logic [7:0] byte_of(logic [47:0] w, int j);
    return 8'((w >> (8 * (5 - j))) & 48'hFF);
  endfunction

  function automatic int wrap(logic [11:0] base, int j);
    return (int'(base) + j) % 4096;
  endfunction

  always @(posedge clk) begin
    if (clr_mem) begin
      for (int i = 0; i < 4096; i++) ref_mem[i] = 8'h00;
    end else if (m_k >= 1 && m_k <= 6 && m_write) begin
      ref_mem[wrap(m_adr, m_k - 1)] = byte_of(m_wdata, m_k - 1);
    end
    if (reset) begin
      m_k = 0;
    end else if (m_k == 0) begin
      if (req_valid) begin
        m_write = req_write;
        m_adr   = req_adr;
        m_wdata = req_wdata;
        m_rdata = '0;
        if (!req_write)
          for (int j = 0; j < 6; j++) m_rdata = (m_rdata << 8) | 48'(ref_mem[wrap(req_adr, j)]);
        m_k = 1;
      end
    end else if (m_k < 7) begin
      m_k = m_k + 1;
    end else if (resp_ready) begin
      m_k = 0;
    end
  end

  logic chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      logic xf;
      xf = (m_k >= 1 && m_k <= 6);
      chk("req_ready", req_ready, m_k == 0);
      chk("resp_valid", resp_valid, m_k == 7);
      if (m_k == 7) chk("resp_rdata", resp_rdata, m_rdata);
      chk("mem_write", mem_write, xf && m_write);
      chk("mem_read", mem_read, xf && !m_write);
      chk("mem_adr", mem_adr, xf ? 12'(wrap(m_adr, m_k - 1)) : 12'h000);
      if (xf && m_write) chk("mem_wdata", mem_wdata, byte_of(m_wdata, m_k - 1));
    end
  end

  logic [11:0] obs_adr [6];
  logic [7:0]  obs_wd  [6];
  logic        obs_wr  [6];
  logic        obs_rd  [6];

  task automatic do_op(input logic wr, input logic [11:0] adr, input logic [47:0] wd,
                       input int hold, input logic hreq,
                       output logic [47:0] rd, output int lat);
    int n;
    n = 0;
    rd = '0;
    lat = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_write = wr;
    req_adr   = adr;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_adr   = 12'($urandom);
    req_wdata = {16'($urandom), 32'($urandom)};
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i <= 6) begin
        obs_adr[i-1] = mem_adr;
        obs_wd[i-1]  = mem_wdata;
        obs_wr[i-1]  = mem_write;
        obs_rd[i-1]  = mem_read;
      end
      if (resp_valid) begin
        lat = i;
        rd  = resp_rdata;
        break;
      end
    end
    if (lat == 0) chk("resp_wait", resp_valid, 1);
    for (int h = 0; h < hold; h++) begin
      if (hreq) begin
        req_valid = 1'b1;
        req_adr   = 12'($urandom);
      end
      @(negedge clk);
      chk("hold_valid", resp_valid, 1);
      chk("hold_rdata", resp_rdata, rd);
      chk("hold_ready", req_ready, 0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  logic [47:0] rd;
  int          lat;
  logic [7:0]  exp_b  [6];
  logic [11:0] exp_a  [6];
  int          acc    [4];
  int          na;
  logic [11:0] pool   [4];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_en  = 1'b1;
    reset   = 1'b0;
    clr_mem = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_strobes", {mem_write, mem_read}, 2'b00);
    chk("rst_mem_adr", mem_adr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_resp_rdata", resp_rdata, 0);

    // Store then load at 0x010
    exp_b = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
    do_op(1'b1, 12'h010, 48'h0123456789AB, 0, 1'b0, rd, lat);
    chk("t1_latency", lat, 7);
    chk("t1_rdata_zero", rd, 0);
    for (int i = 0; i < 6; i++) begin
      chk("t1_adr", obs_adr[i], 12'h010 + 12'(i));
      chk("t1_wdata", obs_wd[i], exp_b[i]);
      chk("t1_write", obs_wr[i], 1);
    end
    do_op(1'b0, 12'h010, 48'h0, 0, 1'b0, rd, lat);
    chk("t2_latency", lat, 7);
    chk("t2_rdata", rd, 48'h0123456789AB);
    for (int i = 0; i < 6; i++) chk("t2_read", {obs_rd[i], obs_wr[i]}, 2'b10);

    // Wrap-around at 0xFFE
    exp_a = '{12'hFFE, 12'hFFF, 12'h000, 12'h001, 12'h002, 12'h003};
    do_op(1'b1, 12'hFFE, 48'hCAFEBABE1234, 0, 1'b0, rd, lat);
    for (int i = 0; i < 6; i++) chk("t3_adr", obs_adr[i], exp_a[i]);
    do_op(1'b0, 12'hFFE, 48'h0, 0, 1'b0, rd, lat);
    chk("t3_load", rd, 48'hCAFEBABE1234);

    // Response stall with a competing request
    do_op(1'b0, 12'hFFE, 48'h0, 5, 1'b1, rd, lat);
    chk("t4_rdata", rd, 48'hCAFEBABE1234);

    // Back-to-back loads with req_valid held high
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_adr    = 12'h010;
    na = 0;
    for (int i = 0; i < 24; i++) begin
      if (req_valid && req_ready && na < 4) begin
        acc[na] = i;
        na++;
      end
      if (resp_valid) chk("t6_rdata", resp_rdata, 48'h0123456789AB);
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    chk("t6_accepts", na, 3);
    chk("t6_acc0", acc[0], 0);
    chk("t6_acc1", acc[1], 8);
    chk("t6_acc2", acc[2], 16);

    // Reset during a store after two bytes have been written
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_adr   = 12'h800;
    req_wdata = 48'h111213141516;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_write_low", mem_write, 0);
    chk("t5_ready", req_ready, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t5_no_resp", resp_valid, 0);
    end
    chk("t5_b0", mem[12'h800], 8'h11);
    chk("t5_b1", mem[12'h801], 8'h12);
    for (int i = 2; i < 6; i++) chk("t5_untouched", mem[12'h800 + 12'(i)], 8'h00);

    // Random traffic over a small address pool plus the wrap region
    pool = '{12'h123, 12'h400, 12'hFFB, 12'hFFD};
    for (int n = 0; n < 40; n++) begin
      logic [11:0] a;
      a = ($urandom_range(0, 3) == 0) ? 12'($urandom) : pool[$urandom_range(0, 3)];
      do_op(1'($urandom), a, {16'($urandom), 32'($urandom)}, int'($urandom_range(0, 3)),
            1'($urandom), rd, lat);
      chk("rand_latency", lat, 7);
    end
    for (int i = 0; i < 4096; i++)
      if (mem[i] !== ref_mem[i]) chk("final_mem", mem[i], ref_mem[i]);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
